// File: rtl/dtcore32_pkg.sv
// Shared constants and types for the dtcore32 register file.
// Holds the default widths and the regfile FSM state encoding.
package dtcore32_pkg;

  localparam int DT_XLEN     = 32;
  localparam int DT_NUM_REGS = 32;

  typedef enum logic {
    REGFILE_INIT = 1'b0,
    REGFILE_RUN  = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/dtcore32_regfile_rdport.sv
// One combinational read port: array lookup, optional same-cycle write forwarding,
// and busy lookup. Output is forced to zero for x0 and while the sweep is running.
module dtcore32_regfile_rdport
  import dtcore32_pkg::*;
#(
  parameter  int XLEN      = DT_XLEN,
  parameter  int NUM_REGS  = DT_NUM_REGS,
  parameter  bit BYPASS_EN = 1'b1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                               ready_i,
  input  logic [AW-1:0]                      rd_addr_i,
  input  logic [NUM_REGS-1:0][XLEN-1:0]      regs_i,
  input  logic [NUM_REGS-1:0]                busy_i,
  input  logic [1:0]                         wr_en_i,
  input  logic [1:0][AW-1:0]                 wr_addr_i,
  input  logic [1:0][XLEN-1:0]               wr_data_i,
  output logic [XLEN-1:0]                    rd_data_o,
  output logic                               rd_busy_o
);

  logic addr_zero;
  assign addr_zero = (rd_addr_i == '0);

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (ready_i && !addr_zero) begin
      rd_data_o = regs_i[rd_addr_i];
      rd_busy_o = busy_i[rd_addr_i];
      // Later port overrides earlier so the load port wins, matching commit order.
      if (BYPASS_EN) begin
        for (int k = 0; k < 2; k++) begin
          if (wr_en_i[k] && (wr_addr_i[k] == rd_addr_i))
            rd_data_o = wr_data_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/dtcore32_regfile_mp.sv
// Multi-read, dual-write register file with per-register busy scoreboard bits.
// After reset an INIT sweep zeroes x1..x(NUM_REGS-1) one per cycle before accepting traffic.
module dtcore32_regfile_mp
  import dtcore32_pkg::*;
#(
  parameter  int XLEN         = DT_XLEN,
  parameter  int NUM_REGS     = DT_NUM_REGS,
  parameter  int NUM_RD_PORTS = 2,
  parameter  bit BYPASS_EN    = 1'b1,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  output logic                                  ready_o,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]       rd_addr_i,
  output logic [NUM_RD_PORTS-1:0][XLEN-1:0]     rd_data_o,
  output logic [NUM_RD_PORTS-1:0]               rd_busy_o,
  input  logic [1:0]                            wr_en_i,
  input  logic [1:0][AW-1:0]                    wr_addr_i,
  input  logic [1:0][XLEN-1:0]                  wr_data_i,
  input  logic                                  busy_set_i,
  input  logic [AW-1:0]                         busy_set_addr_i
);

  regfile_state_e                state_q;
  logic [AW-1:0]                 cnt_q;
  logic                          ready_q;
  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0]           busy_q, busy_d;
  logic [1:0]                    wr_commit;

  assign ready_o   = ready_q;
  assign wr_commit = wr_en_i & {2{ready_q}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REGFILE_INIT;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        REGFILE_INIT: begin
          if (cnt_q == AW'(NUM_REGS-1)) begin
            state_q <= REGFILE_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= REGFILE_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // No reset on the array: contents are only defined by the sweep.
  always_ff @(posedge clk_i) begin
    if (state_q == REGFILE_INIT) begin
      regs_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k] != '0))
          regs_q[wr_addr_i[k]] <= wr_data_i[k];
      end
    end
  end

  // Clear on commit first, then set, so a new producer survives its predecessor's write.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++) begin
      if (wr_commit[k])
        busy_d[wr_addr_i[k]] = 1'b0;
    end
    if (busy_set_i)
      busy_d[busy_set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      busy_q <= '0;
    else if (ready_q)
      busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    dtcore32_regfile_rdport #(
      .XLEN      (XLEN),
      .NUM_REGS  (NUM_REGS),
      .BYPASS_EN (BYPASS_EN)
    ) u_rdport (
      .ready_i   (ready_q),
      .rd_addr_i (rd_addr_i[p]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .wr_en_i   (wr_commit),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_data_o (rd_data_o[p]),
      .rd_busy_o (rd_busy_o[p])
    );
  end

endmodule

// File: tb/tb_dtcore32_regfile_mp.sv
// Bench for dtcore32_regfile_mp: a forwarding and a non-forwarding instance share stimulus;
// table vectors go through a scoreboard queue, reset/sweep corners are hand sequences.
module tb_dtcore32_regfile_mp;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NP   = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]              wr_en;
  logic [1:0][AW-1:0]      wr_addr;
  logic [1:0][XLEN-1:0]    wr_data;
  logic                    busy_set;
  logic [AW-1:0]           busy_addr;
  logic [NP-1:0][AW-1:0]   rd_addr;
  logic                    ready, ready_nb;
  logic [NP-1:0][XLEN-1:0] rd_data, rd_data_nb;
  logic [NP-1:0]           rd_busy, rd_busy_nb;

  int n_chk  = 0;
  int n_fail = 0;

  dtcore32_regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .BYPASS_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ready_o(ready),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_set_i(busy_set), .busy_set_addr_i(busy_addr)
  );

  dtcore32_regfile_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .BYPASS_EN(1'b0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .ready_o(ready_nb),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_set_i(busy_set), .busy_set_addr_i(busy_addr)
  );

  typedef struct {
    string            name;
    logic [1:0]       we;
    logic [AW-1:0]    wa0, wa1;
    logic [XLEN-1:0]  wd0, wd1;
    logic             bs;
    logic [AW-1:0]    ba;
    logic [AW-1:0]    ra0, ra1;
    logic [XLEN-1:0]  e0, e1;     // forwarding instance
    logic [XLEN-1:0]  e0n, e1n;   // committed-state instance
    logic             b0, b1;
  } vec_t;

  vec_t tbl[15];
  vec_t sb[$];

  function automatic vec_t mk(string nm, logic [1:0] we, int wa0, int wd0, int wa1, int wd1,
                              logic bs, int ba, int ra0, int ra1,
                              int e0, int e1, int e0n, int e1n, logic b0, logic b1);
    vec_t v;
    v.name = nm; v.we = we;
    v.wa0 = AW'(wa0); v.wd0 = XLEN'(wd0); v.wa1 = AW'(wa1); v.wd1 = XLEN'(wd1);
    v.bs = bs; v.ba = AW'(ba); v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.e0 = XLEN'(e0); v.e1 = XLEN'(e1); v.e0n = XLEN'(e0n); v.e1n = XLEN'(e1n);
    v.b0 = b0; v.b1 = b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0; rd_addr = '0;
  endtask

  task automatic apply(vec_t v);
    wr_en = v.we;
    wr_addr[0] = v.wa0; wr_data[0] = v.wd0;
    wr_addr[1] = v.wa1; wr_data[1] = v.wd1;
    busy_set = v.bs; busy_addr = v.ba;
    rd_addr[0] = v.ra0; rd_addr[1] = v.ra1;
  endtask

  // Count rising edges after reset release until ready; reads must stay zero meanwhile.
  task automatic wait_ready(input bit poke, output int cyc);
    cyc = 0;
    if (poke) begin
      wr_en = 2'b11; wr_addr[0] = AW'(1); wr_data[0] = 32'hAAAA_AAAA;
      wr_addr[1] = AW'(2); wr_data[1] = 32'h5555_5555;
      busy_set = 1'b1; busy_addr = AW'(2);
    end
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
      chk("sweep_ready_nb", {31'd0, ready_nb}, 32'd0);
      chk("sweep_rd0", rd_data[0], '0);
      chk("sweep_rd1_nb", rd_data_nb[1], '0);
      chk("sweep_busy", {30'd0, rd_busy}, 32'd0);
      rd_addr[0] = AW'(cyc);
      rd_addr[1] = AW'(31 - cyc);
    end
    set_idle();
    chk("sweep_cycles", XLEN'(cyc), 32'd31);
    chk("ready_nb_after_sweep", {31'd0, ready_nb}, 32'd1);
  endtask

  initial begin
    int cyc;
    vec_t e;
    set_idle();

    tbl[0]  = mk("byp_x5",       2'b01, 5, 32'hDEADBEEF, 0, 0,      0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk("commit_x5",    2'b00, 0, 0, 0, 0,                 0, 0, 5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);
    tbl[2]  = mk("dual_x7",      2'b11, 7, 32'h1111, 7, 32'h2222,   0, 0, 7, 7, 32'h2222, 32'h2222, 0, 0, 0, 0);
    tbl[3]  = mk("dual_x7_next", 2'b00, 0, 0, 0, 0,                 0, 0, 7, 5, 32'h2222, 32'hDEADBEEF, 32'h2222, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk("bset_x9",      2'b00, 0, 0, 0, 0,                 1, 9, 9, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk("wr_bset_x9",   2'b01, 9, 32'hAB, 0, 0,            1, 9, 9, 9, 32'hAB, 32'hAB, 0, 0, 1, 1);
    tbl[6]  = mk("x9_still_bsy", 2'b00, 0, 0, 0, 0,                 0, 0, 9, 0, 32'hAB, 0, 32'hAB, 0, 1, 0);
    tbl[7]  = mk("wr_x9_clear",  2'b10, 0, 0, 9, 32'hCD,            0, 0, 9, 0, 32'hCD, 0, 32'hAB, 0, 1, 0);
    tbl[8]  = mk("x9_cleared",   2'b00, 0, 0, 0, 0,                 0, 0, 9, 9, 32'hCD, 32'hCD, 32'hCD, 32'hCD, 0, 0);
    tbl[9]  = mk("wr_x0",        2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk("x0_next",      2'b00, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk("wr_x3_x4",     2'b11, 3, 32'h55, 4, 32'h66,       0, 0, 3, 4, 32'h55, 32'h66, 0, 0, 0, 0);
    tbl[12] = mk("x3_x4_next",   2'b00, 0, 0, 0, 0,                 0, 0, 3, 4, 32'h55, 32'h66, 32'h55, 32'h66, 0, 0);
    tbl[13] = mk("wr_disabled",  2'b00, 3, 32'h99, 4, 32'h77,       0, 0, 3, 4, 32'h55, 32'h66, 32'h55, 32'h66, 0, 0);
    tbl[14] = mk("wr_dis_next",  2'b00, 0, 0, 0, 0,                 0, 0, 3, 4, 32'h55, 32'h66, 32'h55, 32'h66, 0, 0);

    // Power-on reset and first sweep, with writes/busy_set attempted during INIT.
    #2;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_rd0", rd_data[0], '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wait_ready(1'b1, cyc);
    for (int a = 0; a < NR; a++) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(NR - 1 - a);
      #1;
      chk("post_sweep_rd0", rd_data[0], '0);
      chk("post_sweep_rd1_nb", rd_data_nb[1], '0);
      chk("post_sweep_busy", {30'd0, rd_busy}, 32'd0);
    end
    set_idle();

    // Table vectors through the scoreboard: push at drive, pop at sample.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, "_rd0"},     rd_data[0],    e.e0);
      chk({e.name, "_rd1"},     rd_data[1],    e.e1);
      chk({e.name, "_rd0_nb"},  rd_data_nb[0], e.e0n);
      chk({e.name, "_rd1_nb"},  rd_data_nb[1], e.e1n);
      chk({e.name, "_busy0"},   {31'd0, rd_busy[0]},    {31'd0, e.b0});
      chk({e.name, "_busy1_nb"},{31'd0, rd_busy_nb[1]}, {31'd0, e.b1});
    end
    @(posedge clk); #1;
    set_idle();

    // Mark x12 busy, then reset in RUN: ready drops without a clock edge.
    busy_set = 1'b1; busy_addr = AW'(12);
    @(posedge clk); #1;
    set_idle();
    rd_addr[0] = AW'(12); rd_addr[1] = AW'(3);
    #1;
    chk("x12_busy_pre_reset", {31'd0, rd_busy[0]}, 32'd1);
    chk("x3_pre_reset", rd_data[1], 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("run_reset_ready", {31'd0, ready}, 32'd0);
    chk("run_reset_ready_nb", {31'd0, ready_nb}, 32'd0);
    chk("run_reset_rd_x3", rd_data[1], '0);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();

    // Reset again with the counter at 10.
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_sweep_reset_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(1'b0, cyc);
    rd_addr[0] = AW'(3); rd_addr[1] = AW'(12);
    #1;
    chk("x3_after_resweep", rd_data[0], '0);
    chk("x3_after_resweep_nb", rd_data_nb[0], '0);
    chk("x12_busy_after_reset", {31'd0, rd_busy[1]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dtcore32_regfile_mp.md
DTCORE32_REGFILE_MP -- requirements
Module: dtcore32_regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning architectural register count, power of two, at least 4.
REQ-003 The block SHALL have parameter NUM_RD_PORTS, default 2, meaning independent combinational read ports, 1 to 4.
REQ-004 The block SHALL have parameter BYPASS_EN, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-005 The block SHALL derive AW = clog2(NUM_REGS) as the register address width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-007 clk_i  input  1  clock; all state updates on rising edge.
REQ-008 rst_ni  input  1  asynchronous active-low reset.
REQ-009 ready_o  output  1  high once the initialisation sweep is complete.
REQ-010 rd_addr_i  input  NUM_RD_PORTS x AW  read addresses.
REQ-011 rd_data_o  output  NUM_RD_PORTS x XLEN  read data.
REQ-012 rd_busy_o  output  NUM_RD_PORTS  pending-writer flag per read port.
REQ-013 wr_en_i, wr_addr_i, wr_data_i  input  2, 2 x AW, 2 x XLEN  write port 0 (ALU) and write port 1 (load).
REQ-014 busy_set_i, busy_set_addr_i  input  1, AW  marks a register as having an in-flight producer.

Function
REQ-015 Writes SHALL commit on the rising clock edge when wr_en_i[k]=1 and ready_o=1.
REQ-016 When both write ports target the same address in one cycle, port 1 SHALL win.
REQ-017 Writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0 with busy 0.
REQ-018 Reads SHALL be combinational, with zero latency.
REQ-019 When BYPASS_EN=1, a read matching an active write address in the same cycle SHALL return that write's data, with port 1 taking priority over port 0.
REQ-020 When BYPASS_EN=0, reads SHALL return only committed state.
REQ-021 Each busy bit SHALL be set by busy_set_i and cleared by a committed write to its address.
REQ-022 When set and clear hit the same address in the same cycle, the busy bit SHALL end set (new producer wins).
REQ-023 rd_busy_o SHALL reflect the registered busy bits, with no bypass applied.
REQ-024 The block SHALL implement a two-state FSM, INIT and RUN.
REQ-025 In INIT, a counter starting at 1 SHALL write zero to one entry per cycle up to NUM_REGS-1, then the FSM SHALL move to RUN.
REQ-026 INIT SHALL last exactly NUM_REGS-1 cycles after reset release.
REQ-027 ready_o SHALL be 1 only in RUN.
REQ-028 During INIT, write ports and busy_set_i SHALL be ignored, and rd_data_o and rd_busy_o SHALL read 0.
REQ-029 RUN SHALL be terminal until the next reset.

Reset
REQ-030 Asserting rst_ni low at any time SHALL asynchronously force INIT, counter=1, all busy bits=0 and ready_o=0.
REQ-031 Array contents SHALL NOT be reset directly; they are zeroed by the INIT sweep only.
REQ-032 A reset asserted mid-sweep or mid-operation SHALL restart the full sweep.

Structure
REQ-033 Shared package dtcore32_pkg SHALL hold the FSM state enum (REGFILE_INIT, REGFILE_RUN) and the default XLEN/NUM_REGS constants.
REQ-034 The per-port read and bypass mux SHALL be one sub-module, dtcore32_regfile_rdport, instantiated NUM_RD_PORTS times.
REQ-035 The storage array SHALL be inferable as flops or distributed RAM, with no reset on the array.

Verification
REQ-036 The bench SHALL cover reset release with NUM_REGS=32: ready_o rises after exactly 31 cycles, and all reads return 0 during and after the sweep.
REQ-037 The bench SHALL cover a port-0 write of x5=0xDEADBEEF with rd_addr_i[0]=5 in the same cycle: rd_data_o[0]=0xDEADBEEF that cycle with BYPASS_EN=1, and 0 that cycle then 0xDEADBEEF next cycle with BYPASS_EN=0.
REQ-038 The bench SHALL cover ports 0 and 1 both writing x7, with 0x1111 and 0x2222 respectively: the next-cycle read of x7 returns 0x2222.
REQ-039 The bench SHALL cover busy_set on x9, then a write of x9 in the same cycle as a new busy_set on x9: rd_busy_o stays 1, and a later write alone clears it to 0.
REQ-040 The bench SHALL cover a write of x0=0xFFFFFFFF and busy_set on x0: the read of x0 returns 0 with busy 0.
REQ-041 The bench SHALL cover rst_ni pulsed low at sweep count 10, then at RUN with x3=0x55: ready_o drops immediately, the sweep restarts with 31 cycles, and x3 reads 0 afterwards.
